redmule_w_loader: RTL

Row assembler directly upstream of the W buffer. It collects one row of weights as a stream of column beats from the W memory streamer, with ELMS words per beat and COLS beats per row. It then issues one full-row write to the buffer at a wrapping row address. Row-level credit flow control ensures no row the engine has not yet released is ever overwritten.

---
 rtl/redmule_w_loader_pkg.sv | 31 +++
 rtl/redmule_w_loader_if.sv | 31 +++
 rtl/redmule_w_loader_credit_cnt.sv | 29 ++
 rtl/redmule_w_loader.sv | 103 ++++++++++
 4 files changed

// File: rtl/redmule_w_loader_pkg.sv
// Shared W-path definitions: default geometry, counter/index width helpers and
// the row-write record handed to the W buffer.
package redmule_w_loader_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned ROWS      = 4;
  localparam int unsigned COLS      = 4;
  localparam int unsigned ELMS      = 4;

  // Index width that stays at least 1 bit when there is a single entry.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold every value 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned ADDR_W = idx_w(ROWS);
  localparam int unsigned CNT_W  = cnt_w(ROWS);

  typedef logic [COLS-1:0][ELMS-1:0][WORD_SIZE-1:0] row_data_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    row_data_t         data;
  } row_write_t;

endpackage

// File: rtl/redmule_w_loader_if.sv
// Beat stream in, row writes and row release/occupancy out.
interface redmule_w_loader_if #(
  parameter int unsigned WORD_SIZE = redmule_w_loader_pkg::WORD_SIZE,
  parameter int unsigned ROWS      = redmule_w_loader_pkg::ROWS,
  parameter int unsigned COLS      = redmule_w_loader_pkg::COLS,
  parameter int unsigned ELMS      = redmule_w_loader_pkg::ELMS
);

  localparam int unsigned AW = redmule_w_loader_pkg::idx_w(ROWS);
  localparam int unsigned NW = redmule_w_loader_pkg::cnt_w(ROWS);

  logic                                      in_valid_i;
  logic                                      in_ready_o;
  logic [ELMS*WORD_SIZE-1:0]                 in_data_i;
  logic                                      row_free_i;
  logic                                      write_en_o;
  logic [AW-1:0]                             write_addr_o;
  logic [COLS-1:0][ELMS-1:0][WORD_SIZE-1:0]  wdata_o;
  logic [NW-1:0]                             rows_avail_o;

  modport slave (
    input  in_valid_i, in_data_i, row_free_i,
    output in_ready_o, write_en_o, write_addr_o, wdata_o, rows_avail_o
  );

  modport master (
    output in_valid_i, in_data_i, row_free_i,
    input  in_ready_o, write_en_o, write_addr_o, wdata_o, rows_avail_o
  );

endinterface

// File: rtl/redmule_w_loader_credit_cnt.sv
// Saturating up/down counter with synchronous clear to a parameterised init value.
module redmule_credit_cnt #(
  parameter int unsigned MAX   = 4,
  parameter int unsigned INIT  = 0,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt;

  // Coincident inc/dec cancel; each direction saturates at its bound.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      cnt <= WIDTH'(INIT);
    end else if (inc_i && !dec_i && cnt != WIDTH'(MAX)) begin
      cnt <= cnt + 1'b1;
    end else if (dec_i && !inc_i && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign cnt_o = cnt;

endmodule

// File: rtl/redmule_w_loader.sv
// Assembles COLS beats of ELMS words into one row and writes it to the W buffer
// at a wrapping address, holding off new rows until the consumer frees a slot.
module redmule_w_loader #(
  parameter int unsigned WORD_SIZE = redmule_w_loader_pkg::WORD_SIZE,
  parameter int unsigned ROWS      = redmule_w_loader_pkg::ROWS,
  parameter int unsigned COLS      = redmule_w_loader_pkg::COLS,
  parameter int unsigned ELMS      = redmule_w_loader_pkg::ELMS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  redmule_w_loader_if.slave     bus
);

  import redmule_w_loader_pkg::*;

  localparam int unsigned AW = idx_w(ROWS);
  localparam int unsigned CW = idx_w(COLS);
  localparam int unsigned NW = cnt_w(ROWS);

  logic [CW-1:0]                             col_cnt;
  logic [AW-1:0]                             wr_ptr;
  logic                                      wr_pend;
  logic [COLS-1:0][ELMS-1:0][WORD_SIZE-1:0]  staging;
  logic [NW-1:0]                             credit;
  logic [NW-1:0]                             rows_avail;

  logic flush;
  logic ready;
  logic accept;
  logic first_col;
  logic last_col;
  logic reserve;
  logic release_ok;

  always_comb begin
    flush      = rst_i || clear_i;
    first_col  = (col_cnt == '0);
    last_col   = (col_cnt == CW'(COLS - 1));
    // A started row always completes; only a fresh row needs a free slot.
    ready      = !rst_i && (!first_col || credit != '0);
    accept     = bus.in_valid_i && ready;
    reserve    = accept && first_col;
    release_ok = bus.row_free_i && (rows_avail != '0);
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      col_cnt <= '0;
      wr_ptr  <= '0;
      wr_pend <= 1'b0;
      staging <= '0;
    end else begin
      wr_pend <= accept && last_col;
      if (accept) begin
        staging[col_cnt] <= bus.in_data_i;
        col_cnt          <= last_col ? '0 : col_cnt + 1'b1;
      end
      if (wr_pend) begin
        wr_ptr <= (wr_ptr == AW'(ROWS - 1)) ? '0 : wr_ptr + 1'b1;
      end
    end
  end

  redmule_credit_cnt #(
    .MAX   (ROWS),
    .INIT  (ROWS),
    .WIDTH (NW)
  ) u_credit (
    .clk_i   (clk_i),
    .clear_i (flush),
    .inc_i   (release_ok),
    .dec_i   (reserve),
    .cnt_o   (credit)
  );

  redmule_credit_cnt #(
    .MAX   (ROWS),
    .INIT  (0),
    .WIDTH (NW)
  ) u_rows_avail (
    .clk_i   (clk_i),
    .clear_i (flush),
    .inc_i   (wr_pend),
    .dec_i   (release_ok),
    .cnt_o   (rows_avail)
  );

  // Slots are either free, reserved by an in-flight row, or holding a written row.
  always_ff @(posedge clk_i) begin
    if (!flush) begin
      assert (32'(credit) + 32'(rows_avail) <= ROWS)
        else $error("credit/rows_avail exceed buffer rows");
    end
  end

  assign bus.in_ready_o   = ready;
  assign bus.write_en_o   = wr_pend;
  assign bus.write_addr_o = wr_ptr;
  assign bus.wdata_o      = staging;
  assign bus.rows_avail_o = rows_avail;

endmodule
